id_ex_operand_stage: RTL and testbench

- ID/EX pipeline stage directly upstream of the execute-stage ALU, which contains the add/sub and set-less-than compare units.
- Accepts decoded instruction fields from decode over a valid/ready handshake.
- Selects operand B: rs2 data or the immediate.
- Registers the operands and ALU control and presents them to the ALU with its own valid/ready handshake.
- A 2-entry skid buffer provides full throughput under back-pressure. A flush input kills in-flight ops on branch mispredict.

---
 rtl/riscv_pkg.sv | 46 ++++
 rtl/pipe_skid_buffer.sv | 127 ++++++++++++
 rtl/id_ex_operand_stage.sv | 95 +++++++++
 tb/tb_id_ex_operand_stage.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// -----------------------------------------------------------------------------
// riscv_pkg
//   Shared definitions for the decode -> execute boundary.
//   - XLEN / CTRL_W / RD_W      : datapath, ALU control and register index widths
//   - ALU_* codes               : alu_control_signal encodings seen by the ALU
//   - ex_op_t                   : one fully decoded op as held between ID and EX
//   - sb_state_e                : occupancy state of the 2-entry skid buffer
// -----------------------------------------------------------------------------
package riscv_pkg;

   localparam int XLEN   = 64;
   localparam int CTRL_W = 4;
   localparam int RD_W   = 5;

   // ALU control encodings. Bit 3 selects subtraction in the add/sub unit;
   // for the set-less-than pair bit 0 selects the unsigned compare.
   localparam logic [CTRL_W-1:0] ALU_ADD  = 4'b0000;
   localparam logic [CTRL_W-1:0] ALU_SUB  = 4'b1000;
   localparam logic [CTRL_W-1:0] ALU_SLT  = 4'b0010;
   localparam logic [CTRL_W-1:0] ALU_SLTU = 4'b0011;
   localparam logic [CTRL_W-1:0] ALU_AND  = 4'b0111;
   localparam logic [CTRL_W-1:0] ALU_OR   = 4'b0110;
   localparam logic [CTRL_W-1:0] ALU_XOR  = 4'b0100;

   // Operand B is stored already muxed, so the execute stage never sees
   // alu_src; rs2_data rides along for stores.
   typedef struct packed {
      logic [XLEN-1:0]   a;
      logic [XLEN-1:0]   b;
      logic [CTRL_W-1:0] alu_ctrl;
      logic [XLEN-1:0]   rs2_data;
      logic [RD_W-1:0]   rd;
      logic              reg_write;
   } ex_op_t;

   localparam int EX_OP_W = $bits(ex_op_t);

   // Encoding is {skid_valid, main_valid}, so the valid bits fall straight
   // out of the state register.
   typedef enum logic [1:0] {
      SB_EMPTY = 2'b00,
      SB_ONE   = 2'b01,
      SB_FULL  = 2'b11
   } sb_state_e;

endpackage

// File: rtl/pipe_skid_buffer.sv
// -----------------------------------------------------------------------------
// pipe_skid_buffer
//   Generic 2-entry valid/ready skid buffer. Full throughput when the consumer
//   is always ready; absorbs one extra op when the consumer stalls, so the
//   producer-side ready can be a plain flop.
//
//   Handshake: a transfer happens on a rising edge where valid && ready on the
//   same side. Once out_valid is high, out_data is held bit-for-bit until the
//   transfer. in_ready comes straight from the state register and never
//   depends combinationally on out_ready or flush.
//
//   Ports
//     clk, rst_n     : clock, asynchronous active-low reset
//     flush          : synchronous kill of both slots (highest priority)
//     in_valid/ready : producer handshake
//     in_data [W]    : producer payload
//     out_valid/ready: consumer handshake
//     out_data [W]   : consumer payload (main slot)
//     state          : occupancy state, for debug/checkers
// -----------------------------------------------------------------------------
module pipe_skid_buffer
   import riscv_pkg::*;
#(
   parameter int W = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          flush,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [W-1:0]  in_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [W-1:0]  out_data,
   output sb_state_e     state
);

   sb_state_e      state_q;
   sb_state_e      state_d;
   logic [W-1:0]   main_q;
   logic [W-1:0]   skid_q;

   logic           accept;
   logic           consume;
   logic           load_main_in;
   logic           load_main_skid;
   logic           load_skid;

   assign in_ready  = (state_q != SB_FULL);
   assign out_valid = (state_q != SB_EMPTY);
   assign out_data  = main_q;
   assign state     = state_q;

   assign accept  = in_valid && in_ready;
   assign consume = out_valid && out_ready;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= SB_EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state and slot load strobes
   always_comb begin
      state_d        = state_q;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;

      unique case (state_q)
         SB_EMPTY: begin
            if (accept) begin
               state_d      = SB_ONE;
               load_main_in = 1'b1;
            end
         end
         SB_ONE: begin
            if (accept && consume) begin
               load_main_in = 1'b1;
            end else if (accept) begin
               state_d   = SB_FULL;
               load_skid = 1'b1;
            end else if (consume) begin
               state_d = SB_EMPTY;
            end
         end
         SB_FULL: begin
            // in_ready is low here, so only a consume can move us.
            if (consume) begin
               state_d        = SB_ONE;
               load_main_skid = 1'b1;
            end
         end
         default: begin
            state_d = SB_EMPTY;
         end
      endcase

      // Flush wins over everything. Slot loads may still fire this cycle;
      // that is harmless because the slots are marked invalid.
      if (flush) begin
         state_d = SB_EMPTY;
      end
   end

   // Slot data. Not cleared on flush: stale data in an invalid slot is
   // never presented.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         main_q <= '0;
         skid_q <= '0;
      end else begin
         if (load_main_in) begin
            main_q <= in_data;
         end else if (load_main_skid) begin
            main_q <= skid_q;
         end
         if (load_skid) begin
            skid_q <= in_data;
         end
      end
   end

endmodule

// File: rtl/id_ex_operand_stage.sv
// -----------------------------------------------------------------------------
// id_ex_operand_stage
//   ID/EX pipeline register in front of the execute-stage ALU. Picks operand B
//   (rs2 data or immediate) as the op enters, then holds the op in a 2-entry
//   skid buffer that presents it to the ALU over a valid/ready handshake.
//   flush kills every held op (branch mispredict).
//
//   Ports
//     clk, rst_n                    : clock, asynchronous active-low reset
//     in_valid / in_ready           : decode handshake
//     in_rs1_data, in_rs2_data [XLEN]: source operands
//     in_imm [XLEN]                 : sign-extended immediate
//     in_alu_src                    : 1 = operand B from in_imm, 0 = from rs2
//     in_alu_ctrl [CTRL_W]          : ALU control code
//     in_rd [RD_W], in_reg_write    : writeback destination / enable
//     flush                         : synchronous kill of all held ops
//     out_valid / out_ready         : execute-stage handshake
//     out_a, out_b [XLEN]           : ALU operands (B already muxed)
//     out_alu_ctrl [CTRL_W]         : alu_control_signal
//     out_rs2_data [XLEN]           : rs2 passthrough for stores
//     out_rd [RD_W], out_reg_write  : writeback destination / enable
//     dbg_state                     : skid buffer occupancy state
// -----------------------------------------------------------------------------
module id_ex_operand_stage
   import riscv_pkg::*;
#(
   parameter int XLEN   = riscv_pkg::XLEN,
   parameter int CTRL_W = riscv_pkg::CTRL_W,
   parameter int RD_W   = riscv_pkg::RD_W
) (
   input  logic              clk,
   input  logic              rst_n,

   input  logic              in_valid,
   output logic              in_ready,
   input  logic [XLEN-1:0]   in_rs1_data,
   input  logic [XLEN-1:0]   in_rs2_data,
   input  logic [XLEN-1:0]   in_imm,
   input  logic              in_alu_src,
   input  logic [CTRL_W-1:0] in_alu_ctrl,
   input  logic [RD_W-1:0]   in_rd,
   input  logic              in_reg_write,

   input  logic              flush,

   output logic              out_valid,
   input  logic              out_ready,
   output logic [XLEN-1:0]   out_a,
   output logic [XLEN-1:0]   out_b,
   output logic [CTRL_W-1:0] out_alu_ctrl,
   output logic [XLEN-1:0]   out_rs2_data,
   output logic [RD_W-1:0]   out_rd,
   output logic              out_reg_write,

   output sb_state_e         dbg_state
);

   ex_op_t in_op;
   ex_op_t out_op;

   // Operand B is chosen once, on the way in; the stored value is what the
   // ALU sees, so a held op cannot change if alu_src moves upstream.
   always_comb begin
      in_op           = '0;
      in_op.a         = in_rs1_data;
      in_op.b         = in_alu_src ? in_imm : in_rs2_data;
      in_op.alu_ctrl  = in_alu_ctrl;
      in_op.rs2_data  = in_rs2_data;
      in_op.rd        = in_rd;
      in_op.reg_write = in_reg_write;
   end

   pipe_skid_buffer #(
      .W (EX_OP_W)
   ) u_skid (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_op),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_op),
      .state     (dbg_state)
   );

   assign out_a         = out_op.a;
   assign out_b         = out_op.b;
   assign out_alu_ctrl  = out_op.alu_ctrl;
   assign out_rs2_data  = out_op.rs2_data;
   assign out_rd        = out_op.rd;
   assign out_reg_write = out_op.reg_write;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// -----------------------------------------------------------------------------
// tb_id_ex_operand_stage
//   Directed + randomized bench for id_ex_operand_stage. Ops accepted by the
//   stage are pushed to an expected queue built from the driven inputs; ops
//   leaving the stage are popped and compared. Occupancy (out_valid, in_ready,
//   dbg_state) is checked against the queue depth every cycle.
// -----------------------------------------------------------------------------
module tb_id_ex_operand_stage;
   import riscv_pkg::*;

   // ---------------- clock / reset ----------------
   logic clk;
   logic rst_n;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- DUT signals ----------------
   logic              in_valid;
   logic              in_ready;
   logic [XLEN-1:0]   in_rs1_data;
   logic [XLEN-1:0]   in_rs2_data;
   logic [XLEN-1:0]   in_imm;
   logic              in_alu_src;
   logic [CTRL_W-1:0] in_alu_ctrl;
   logic [RD_W-1:0]   in_rd;
   logic              in_reg_write;
   logic              flush;
   logic              out_valid;
   logic              out_ready;
   logic [XLEN-1:0]   out_a;
   logic [XLEN-1:0]   out_b;
   logic [CTRL_W-1:0] out_alu_ctrl;
   logic [XLEN-1:0]   out_rs2_data;
   logic [RD_W-1:0]   out_rd;
   logic              out_reg_write;
   sb_state_e         dbg_state;

   id_ex_operand_stage dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_rs1_data   (in_rs1_data),
      .in_rs2_data   (in_rs2_data),
      .in_imm        (in_imm),
      .in_alu_src    (in_alu_src),
      .in_alu_ctrl   (in_alu_ctrl),
      .in_rd         (in_rd),
      .in_reg_write  (in_reg_write),
      .flush         (flush),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_a         (out_a),
      .out_b         (out_b),
      .out_alu_ctrl  (out_alu_ctrl),
      .out_rs2_data  (out_rs2_data),
      .out_rd        (out_rd),
      .out_reg_write (out_reg_write),
      .dbg_state     (dbg_state)
   );

   // ---------------- scoreboard ----------------
   logic [EX_OP_W-1:0] exp_q[$];
   int                 n_checks = 0;
   int                 n_errs   = 0;
   int                 n_out    = 0;
   logic               stall_prev = 1'b0;
   logic [EX_OP_W-1:0] stall_snap = '0;

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] expv);
      n_checks++;
      assert (obs === expv) else begin
         n_errs++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   function automatic logic [EX_OP_W-1:0] model_op();
      ex_op_t op;
      op.a         = in_rs1_data;
      op.b         = in_alu_src ? in_imm : in_rs2_data;
      op.alu_ctrl  = in_alu_ctrl;
      op.rs2_data  = in_rs2_data;
      op.rd        = in_rd;
      op.reg_write = in_reg_write;
      return op;
   endfunction

   function automatic logic [EX_OP_W-1:0] cur_out();
      return {out_a, out_b, out_alu_ctrl, out_rs2_data, out_rd, out_reg_write};
   endfunction

   // One clock: sample at negedge, update the model, then step past posedge.
   task automatic tick();
      logic               acc;
      logic               con;
      logic [EX_OP_W-1:0] cur;
      logic [EX_OP_W-1:0] want;
      sb_state_e          exp_st;
      @(negedge clk);
      cur    = cur_out();
      exp_st = (exp_q.size() == 0) ? SB_EMPTY : (exp_q.size() == 1) ? SB_ONE : SB_FULL;
      chk("out_valid", 256'(out_valid), 256'(exp_q.size() != 0));
      chk("in_ready",  256'(in_ready),  256'(exp_q.size() < 2));
      chk("dbg_state", 256'(dbg_state), 256'(exp_st));
      if (stall_prev && out_valid) chk("hold_stable", 256'(cur), 256'(stall_snap));
      acc = in_valid && in_ready;
      con = out_valid && out_ready;
      if (con) begin
         n_out++;
         if (exp_q.size() == 0) begin
            chk("spurious_out", 256'(out_valid), 256'(0));
         end else begin
            want = exp_q.pop_front();
            chk("out_op", 256'(cur), 256'(want));
         end
      end
      if (flush) exp_q.delete();
      else if (acc) exp_q.push_back(model_op());
      stall_prev = out_valid && !out_ready;
      stall_snap = cur;
      @(posedge clk);
      #1;
   endtask

   // ---------------- driver helpers ----------------
   task automatic rand_fields();
      in_rs1_data  = {$urandom, $urandom};
      in_rs2_data  = {$urandom, $urandom};
      in_imm       = {$urandom, $urandom};
      in_alu_src   = 1'($urandom_range(0, 1));
      in_alu_ctrl  = 4'($urandom_range(0, 15));
      in_rd        = 5'($urandom_range(0, 31));
      in_reg_write = 1'($urandom_range(0, 1));
   endtask

   task automatic send(input logic [RD_W-1:0] rd);
      rand_fields();
      in_rd    = rd;
      in_valid = 1'b1;
      tick();
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int start_out;

      // Reset with random inputs
      rst_n     = 1'b0;
      flush     = 1'b0;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      rand_fields();
      repeat (3) @(negedge clk);
      chk("rst_out_valid", 256'(out_valid), 256'(0));
      chk("rst_in_ready",  256'(in_ready),  256'(1));
      chk("rst_out_a",     256'(out_a),     256'(0));
      chk("rst_out_b",     256'(out_b),     256'(0));
      chk("rst_out_rest",  256'({out_alu_ctrl, out_rs2_data, out_rd, out_reg_write}), 256'(0));
      in_valid = 1'b0;
      rst_n    = 1'b1;
      @(posedge clk);
      #1;
      repeat (2) tick();

      // Immediate select, then rs2 select
      in_rs1_data  = 64'd5;
      in_rs2_data  = 64'd9;
      in_imm       = 64'hFFFF_FFFF_FFFF_FFFD;
      in_alu_src   = 1'b1;
      in_alu_ctrl  = ALU_SLT;
      in_rd        = 5'd3;
      in_reg_write = 1'b1;
      in_valid     = 1'b1;
      out_ready    = 1'b1;
      tick();
      chk("imm_out_valid", 256'(out_valid),    256'(1));
      chk("imm_out_a",     256'(out_a),        256'(64'd5));
      chk("imm_out_b",     256'(out_b),        256'(64'hFFFF_FFFF_FFFF_FFFD));
      chk("imm_out_ctrl",  256'(out_alu_ctrl), 256'(ALU_SLT));
      in_alu_src = 1'b0;
      tick();
      chk("rs2_out_b",     256'(out_b),        256'(64'd9));
      chk("rs2_out_a",     256'(out_a),        256'(64'd5));
      in_valid = 1'b0;
      tick();

      // Back-pressure: A (rd 1), B (rd 2), C refused
      out_ready = 1'b0;
      send(5'd1);
      send(5'd2);
      chk("bp_in_ready", 256'(in_ready), 256'(0));
      for (int i = 0; i < 5; i++) begin
         send(5'd3);
         chk("bp_out_rd", 256'(out_rd), 256'(5'd1));
      end

      // Drain from FULL
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      chk("drain_rd2",      256'(out_rd),   256'(5'd2));
      chk("drain_in_ready", 256'(in_ready), 256'(1));
      tick();
      chk("drain_empty",    256'(out_valid), 256'(0));

      // Flush in FULL with a simultaneous input
      out_ready = 1'b0;
      send(5'd4);
      send(5'd5);
      rand_fields();
      in_rd    = 5'd7;
      in_valid = 1'b1;
      flush    = 1'b1;
      tick();
      flush    = 1'b0;
      in_valid = 1'b0;
      chk("flush_out_valid", 256'(out_valid), 256'(0));
      chk("flush_in_ready",  256'(in_ready),  256'(1));
      out_ready = 1'b1;
      repeat (2) tick();

      // Flush in ONE with an output handshake and an input in the same cycle
      send(5'd9);
      rand_fields();
      in_rd    = 5'd10;
      in_valid = 1'b1;
      flush    = 1'b1;
      tick();
      flush    = 1'b0;
      in_valid = 1'b0;
      chk("flush1_out_valid", 256'(out_valid), 256'(0));
      send(5'd11);
      in_valid = 1'b0;
      repeat (2) tick();

      // Asynchronous reset mid-operation
      out_ready = 1'b0;
      send(5'd12);
      send(5'd13);
      in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_out_valid", 256'(out_valid), 256'(0));
      chk("mid_rst_in_ready",  256'(in_ready),  256'(1));
      chk("mid_rst_out_data",  256'(cur_out()), 256'(0));
      exp_q.delete();
      stall_prev = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Streaming: 100 back-to-back ops with out_ready held high
      out_ready = 1'b1;
      start_out = n_out;
      for (int i = 0; i < 100; i++) begin
         send(5'(i % 32));
      end
      in_valid = 1'b0;
      repeat (2) tick();
      chk("stream_count", 256'(n_out - start_out), 256'(100));

      // Random traffic with occasional flush
      for (int i = 0; i < 300; i++) begin
         rand_fields();
         in_valid  = 1'($urandom_range(0, 1));
         out_ready = ($urandom_range(0, 3) != 0);
         flush     = ($urandom_range(0, 15) == 0);
         tick();
      end
      flush     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (3) tick();
      chk("final_queue_empty", 256'(out_valid), 256'(exp_q.size() != 0));

      $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_errs);
      $finish;
   end

endmodule
